// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg
// Shared types and sizing helpers for the iterative shift-add multiplier.
//   state_t     : controller states (IDLE, BUSY, DONE)
//   countWidth  : width of the iteration counter for a given operand width
//   prodWidth   : product width (twice the operand width)
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // The counter only has to reach WIDTH-1, so clog2(WIDTH) bits are enough.
  // The floor of one bit keeps the vector legal for tiny widths.
  function automatic int countWidth(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

  function automatic int prodWidth(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/seq_mult_mult_step.sv
// mult_step
// One combinational shift-add iteration: conditionally adds the shifted
// multiplicand into the running accumulator.
//   acc_i        : running partial-product sum
//   mcand_i      : multiplicand already shifted to this iteration's weight
//   mplier_lsb_i : current multiplier bit
//   acc_o        : accumulator value after this iteration
module mult_step
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [prodWidth(WIDTH)-1:0] acc_i,
  input  logic [prodWidth(WIDTH)-1:0] mcand_i,
  input  logic                        mplier_lsb_i,
  output logic [prodWidth(WIDTH)-1:0] acc_o
);

  // The accumulator is a full product wide, so this add never overflows.
  always_comb begin
    acc_o = acc_i;
    if (mplier_lsb_i) begin
      acc_o = acc_i + mcand_i;
    end
  end

endmodule

// File: rtl/seq_mult.sv
// seq_mult
// Iterative WIDTH x WIDTH shift-add multiplier with valid/ready handshakes on
// both sides. One partial product is folded in per clock; the result appears
// WIDTH cycles after the operands are accepted and is held until taken.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid / in_ready  : operand handshake (a, b)
//   a, b                 : multiplicand and multiplier
//   out_valid / out_ready: product handshake (m)
//   m                    : 2*WIDTH product, held until the next result
// Build option SEQ_MULT_SIGNED_EN: treat a, b and m as two's complement.
// Without it the block is purely unsigned and has no negation logic.
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            a,
  input  logic [WIDTH-1:0]            b,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [prodWidth(WIDTH)-1:0] m
);

  localparam int PW = prodWidth(WIDTH);
  localparam int CW = countWidth(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t            state_q;
  logic [PW-1:0]     acc_q;
  logic [PW-1:0]     acc_d;
  logic [PW-1:0]     mcand_q;
  logic [WIDTH-1:0]  mplier_q;
  logic [CW-1:0]     count_q;
  logic [PW-1:0]     m_q;
  logic              out_valid_q;
  logic              in_ready_q;
  logic [WIDTH-1:0]  aMag;
  logic [WIDTH-1:0]  bMag;
  logic [PW-1:0]     result;

`ifdef SEQ_MULT_SIGNED_EN
  logic sign_q;

  // Magnitudes of the most negative value still fit WIDTH bits when read
  // as unsigned, so the unsigned core handles every signed corner exactly.
  assign aMag   = a[WIDTH-1] ? -a : a;
  assign bMag   = b[WIDTH-1] ? -b : b;
  assign result = sign_q ? -acc_d : acc_d;
`else
  assign aMag   = a;
  assign bMag   = b;
  assign result = acc_d;
`endif

  mult_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .acc_i       (acc_q),
    .mcand_i     (mcand_q),
    .mplier_lsb_i(mplier_q[0]),
    .acc_o       (acc_d)
  );

  // Controller and datapath registers. Latency is fixed at WIDTH iterations
  // even when the multiplier runs out of set bits early.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      count_q     <= '0;
      m_q         <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef SEQ_MULT_SIGNED_EN
      sign_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            mcand_q    <= {{WIDTH{1'b0}}, aMag};
            mplier_q   <= bMag;
            acc_q      <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b0;
            state_q    <= BUSY;
`ifdef SEQ_MULT_SIGNED_EN
            sign_q     <= a[WIDTH-1] ^ b[WIDTH-1];
`endif
          end
        end
        BUSY: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          count_q  <= count_q + CW'(1);
          // The final iteration's sum goes straight into m.
          if (count_q == LAST) begin
            m_q         <= result;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign m         = m_q;

endmodule

// File: tb/tb_seq_mult.sv
// tb_seq_mult
// Self-checking bench for seq_mult at WIDTH=8. Expected products come from a
// plain integer multiply (signed when SEQ_MULT_SIGNED_EN is defined).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_seq_mult;

  localparam int W  = 8;
  localparam int PW = 2 * W;
  localparam int NRAND = 1000;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] m;

  int assertCount = 0;
  int failCount   = 0;
  int cycleNum    = 0;

  seq_mult #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .m        (m)
  );

  // Free-running clock and a posedge count used to measure result spacing.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycleNum <= cycleNum + 1;

  // Reference product straight from integer arithmetic.
  function automatic logic [PW-1:0] refProd(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef SEQ_MULT_SIGNED_EN
    longint sx;
    longint sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    return PW'(sx * sy);
`else
    longint unsigned ux;
    longint unsigned uy;
    ux = 64'(x);
    uy = 64'(y);
    return PW'(ux * uy);
`endif
  endfunction

  // Reset values while reset is held and right after release.
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    assertCount++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || m !== '0) begin
      failCount++;
      $display("[TB] FAIL reset_values: in_ready=%b out_valid=%b m=%h, required 1/0/0", in_ready, out_valid, m);
    end
    rst = 1'b0;
    @(negedge clk);
    assertCount++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset_release: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
    end
  endtask

  // One operation with out_ready high: exact latency, in_ready low while
  // working, operands scrambled after acceptance, then return to idle.
  task automatic test_latency(input logic [W-1:0] x, input logic [W-1:0] y, input string name);
    logic [PW-1:0] expected;
    expected = refProd(x, y);
    for (int k = 0; k < 50 && !in_ready; k++) @(negedge clk);
    a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
    assertCount++;
    if (in_ready !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL %s_accept: in_ready=%b, required 1", name, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0; a = ~x; b = ~y;
    for (int c = 0; c < W; c++) begin
      assertCount++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL %s_busy cycle %0d: out_valid=%b in_ready=%b, required 0/0", name, c, out_valid, in_ready);
      end
      @(negedge clk);
    end
    assertCount++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || m !== expected) begin
      failCount++;
      $display("[TB] FAIL %s_result: out_valid=%b in_ready=%b m=%h, required 1/0/%h", name, out_valid, in_ready, m, expected);
    end
    @(negedge clk);
    out_ready = 1'b0;
    assertCount++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || m !== expected) begin
      failCount++;
      $display("[TB] FAIL %s_idle: out_valid=%b in_ready=%b m=%h, required 0/1/%h", name, out_valid, in_ready, m, expected);
    end
  endtask

  // Result held under output back-pressure; new operands ignored meanwhile.
  task automatic test_hold();
    logic [PW-1:0] expected;
    expected = refProd(8'hFF, 8'hFF);
    a = 8'hFF; b = 8'hFF; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (W) @(negedge clk);
    in_valid = 1'b1; a = 8'h12; b = 8'h34;
    for (int c = 0; c < 5; c++) begin
      assertCount++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || m !== expected) begin
        failCount++;
        $display("[TB] FAIL hold cycle %0d: out_valid=%b in_ready=%b m=%h, required 1/0/%h", c, out_valid, in_ready, m, expected);
      end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    assertCount++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || m !== expected) begin
      failCount++;
      $display("[TB] FAIL hold_release: out_valid=%b in_ready=%b m=%h, required 0/1/%h", out_valid, in_ready, m, expected);
    end
  endtask

  // Three pairs with in_valid held high throughout; results in order and
  // exactly W+2 cycles apart, so nothing is captured while busy.
  task automatic test_back_to_back();
    logic [W-1:0] pa [3];
    logic [W-1:0] pb [3];
    pa[0] = 8'd3;   pb[0] = 8'd5;
    pa[1] = 8'd0;   pb[1] = 8'd200;
    pa[2] = 8'd128; pb[2] = 8'd2;
    out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          a = pa[i]; b = pb[i]; in_valid = 1'b1;
          for (int k = 0; k < 100 && !in_ready; k++) @(negedge clk);
          @(negedge clk);
        end
        in_valid = 1'b0;
      end
      begin
        int lastCycle;
        lastCycle = 0;
        for (int i = 0; i < 3; i++) begin
          int k;
          k = 0;
          while (!out_valid && k < 100) begin
            @(negedge clk);
            k++;
          end
          assertCount++;
          if (out_valid !== 1'b1 || m !== refProd(pa[i], pb[i])) begin
            failCount++;
            $display("[TB] FAIL b2b_result %0d: out_valid=%b m=%h, required 1/%h", i, out_valid, m, refProd(pa[i], pb[i]));
          end
          if (i > 0) begin
            assertCount++;
            if (cycleNum - lastCycle != W + 2) begin
              failCount++;
              $display("[TB] FAIL b2b_spacing %0d: %0d cycles, required %0d", i, cycleNum - lastCycle, W + 2);
            end
          end
          lastCycle = cycleNum;
          @(negedge clk);
        end
      end
    join
    out_ready = 1'b0;
  endtask

  // Reset two cycles into a multiply drops it immediately; no stale result.
  task automatic test_reset_abort();
    a = 8'h5A; b = 8'h3C; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    assertCount++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || m !== '0) begin
      failCount++;
      $display("[TB] FAIL abort_values: out_valid=%b in_ready=%b m=%h, required 0/1/0", out_valid, in_ready, m);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < W + 2; c++) begin
      @(negedge clk);
      assertCount++;
      if (out_valid !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL abort_no_result cycle %0d: out_valid=%b, required 0", c, out_valid);
      end
    end
    out_ready = 1'b0;
    test_latency(8'd9, 8'd9, "after_abort");
  endtask

  // Zero operands and two's-complement extremes, all at fixed latency.
  task automatic test_corners();
    test_latency(8'h00, 8'h37, "a_zero");
    test_latency(8'h37, 8'h00, "b_zero");
    test_latency(8'h80, 8'h80, "neg_max_sq");
    test_latency(8'hFF, 8'h03, "minus1_x3");
    test_latency(8'h03, 8'h80, "x3_neg_max");
  endtask

  // Random operands with random gaps and back-pressure, scoreboarded.
  task automatic test_random();
    logic [PW-1:0] expQ [$];
    int received;
    received = 0;
    fork
      begin
        for (int i = 0; i < NRAND; i++) begin
          int k;
          in_valid = 1'b0;
          repeat ($urandom_range(0, 2)) @(negedge clk);
          a = W'($urandom); b = W'($urandom); in_valid = 1'b1;
          k = 0;
          while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
          end
          assertCount++;
          if (in_ready !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL rand_accept_timeout %0d: in_ready=%b, required 1", i, in_ready);
            break;
          end
          expQ.push_back(refProd(a, b));
          @(negedge clk);
        end
        in_valid = 1'b0;
      end
      begin
        int budget;
        logic [PW-1:0] e;
        budget = 0;
        while (received < NRAND && budget < 60000) begin
          @(negedge clk);
          budget++;
          out_ready = ($urandom_range(0, 3) != 0);
          if (out_valid && out_ready) begin
            assertCount++;
            if (expQ.size() == 0) begin
              failCount++;
              $display("[TB] FAIL rand_extra_result: m=%h, required no result", m);
            end else begin
              e = expQ.pop_front();
              assertCount++;
              if (m !== e) begin
                failCount++;
                $display("[TB] FAIL rand_product %0d: m=%h, required %h", received, m, e);
              end
            end
            received++;
          end
        end
      end
    join
    out_ready = 1'b0;
    assertCount++;
    if (received != NRAND || expQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL rand_count: received=%0d pending=%0d, required %0d/0", received, expQ.size(), NRAND);
    end
  endtask

  initial begin
    test_reset();
    test_latency(8'd7, 8'd7, "seven_sq");
    test_hold();
    test_back_to_back();
    test_reset_abort();
    test_corners();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/seq_mult.md
Name: seq_mult

Overview:
Parametrised iterative shift-add multiplier; WIDTH x WIDTH operands give a 2*WIDTH product.
- Generalises the team's fixed 3x3 combinational array multiplier.
- Trades area for latency, one partial product per cycle.
- Adds valid/ready handshakes on input and output so it sits directly in streaming datapaths between registered stages.

Parameters:
WIDTH, 8, operand width in bits (legal range 2..32); product is 2*WIDTH bits.

Ports:
clk        input   1          single clock, rising edge
rst        input   1          asynchronous reset, active-high
in_valid   input   1          operand pair a/b valid
in_ready   output  1          block can accept operands
a          input   WIDTH      multiplicand
b          input   WIDTH      multiplier
out_valid  output  1          product m valid
out_ready  input   1          downstream accepts product
m          output  2*WIDTH    product a*b

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: in_ready=1, out_valid=0, m=0. Internal state is IDLE; accumulator, operand registers and counter are 0.
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - latch a into mcand (zero-extended to 2*WIDTH) and b into mplier;
  - clear acc; count=0; go to BUSY.
- BUSY: in_ready=0. Each cycle:
  - if mplier[0]: acc += mcand;
  - mcand <<= 1; mplier >>= 1; count++.
  - After WIDTH iterations (count==WIDTH-1 this cycle): register the final acc into m, set out_valid=1, go to DONE.
  - No early termination when mplier becomes zero; latency is fixed.
- DONE: out_valid=1, m stable, in_ready=0. On out_ready: out_valid=0, go to IDLE.
- Latency: handshake accepted at edge N gives out_valid=1 after edge N+WIDTH.
  - Throughput: one product per WIDTH+2 cycles when out_ready is held high.
- m holds its last value after the output handshake until the next result is registered. It is never cleared except by reset.
- Arithmetic:
  - Unsigned modulo nothing: the 2*WIDTH result is exact.
  - Accumulator is 2*WIDTH bits with no overflow possible; max (2^W-1)^2 < 2^(2W).
- Boundaries:
  - a=0 or b=0 gives m=0 with the same fixed latency.
  - in_valid asserted while BUSY/DONE is ignored (not captured); the source must hold it.
  - out_ready asserted in IDLE/BUSY has no effect.
  - Operand changes on a/b after acceptance do not affect the result.
  - rst asserted mid-BUSY or in DONE aborts immediately (asynchronously) to reset values. The pending result is lost.
  - count width is clog2(WIDTH).

Optional Feature:
SEQ_MULT_SIGNED_EN
- Defined: a, b and m are two's complement.
  - On accept, latch |a|, |b| and sign = a[MSB]^b[MSB].
  - Run the unsigned iteration on the magnitudes.
  - When registering m, negate if sign=1.
  - Latency is unchanged.
  - Most-negative × most-negative (e.g. WIDTH=3: -4*-4=+16=6'b010000) must be exact.
- Undefined: purely unsigned, with no negation logic synthesised.

Decomposition:
- Package seq_mult_pkg:
  - state enum (IDLE, BUSY, DONE);
  - localparam helper for the counter width (clog2);
  - product-width function 2*WIDTH.
- One natural sub-module: mult_step. It is a combinational single iteration: inputs acc, mcand, mplier_lsb; output next acc. The top instantiates it once and owns all registers and the FSM.

Test Plan:
1. WIDTH=3, reset, a=7, b=7, in_valid 1 cycle, out_ready=1 -> out_valid rises exactly 3 cycles after accept; m=6'd49 (0x31); in_ready=0 throughout BUSY/DONE.
2. WIDTH=8, a=0xFF, b=0xFF, out_ready held 0 for 5 cycles after out_valid -> m=16'hFE01 held stable; in_ready stays 0; after out_ready pulse, out_valid=0 and in_ready=1 next cycle.
3. WIDTH=8, back-to-back pairs (3,5),(0,200),(128,2) with out_ready=1 -> m=15, 0, 256 in order; each result exactly WIDTH+2 cycles apart; in_valid during BUSY not captured.
4. WIDTH=8, assert rst two cycles into BUSY, then release -> out_valid=0, m=0, in_ready=1 immediately. A new pair (9,9) then yields m=81.
5. SEQ_MULT_SIGNED_EN, WIDTH=3: (-4,-4)->6'd16; (-1,3)->6'b111101 (-3); (3,-4)->-12 (6'b110100); latency 3 cycles each.
6. WIDTH=8 random 1000 pairs with randomized in_valid/out_ready stalls -> every m equals a*b (signed model when macro defined); no lost or duplicated results.
